truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper_pkg.sv | 33 +++
 rtl/truth_table_sweeper_settle.sv | 54 +++++
 rtl/truth_table_sweeper.sv | 162 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper_pkg
// Shared definitions for the truth-table sweeper family: FSM state encoding,
// vector count / index width, and a helper that deposits one captured gate
// output bit into a truth-table word.
// -----------------------------------------------------------------------------
package truth_table_sweeper_pkg;

    // Number of input vectors for a 3-input gate and the index width to walk them.
    localparam int N_VEC = 8;
    localparam int IDX_W = 3;

    // Sweep FSM states; encodings are fixed so external debug taps stay stable.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } sweep_state_e;

    // Return tbl with bit idx replaced by bit_val.
    function automatic logic [N_VEC-1:0] table_insert(
        input logic [N_VEC-1:0] tbl,
        input logic [IDX_W-1:0] idx,
        input logic             bit_val
    );
        logic [N_VEC-1:0] t;
        t      = tbl;
        t[idx] = bit_val;
        return t;
    endfunction

endpackage : truth_table_sweeper_pkg

// File: rtl/truth_table_sweeper_settle.sv
// -----------------------------------------------------------------------------
// settle_timer
// Counts the cycles a stimulus vector has been held. The count restarts on
// clr, advances on en, and expire flags the last settle cycle
// (count == SETTLE-1) so the owner can move on at the next edge.
//
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset (count -> 0)
//   clr    in  1  restart the count at 0 (has priority over en)
//   en     in  1  advance the count by one
//   expire out 1  current count is the final settle cycle
// -----------------------------------------------------------------------------
module settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    // Wide enough to hold SETTLE itself: the count steps once past SETTLE-1
    // on the expiring cycle before the owner clears it.
    localparam int CNT_W = $clog2(SETTLE + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-count selection: clear beats enable, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == CNT_W'(SETTLE - 1));

endmodule : settle_timer

// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
// Drives a 3-input combinational gate through vectors 000..111, holds each
// vector for SETTLE cycles plus one sample cycle, captures the gate output
// into an 8-bit truth table and compares it against a reference latched at
// start.
//
// Ports:
//   clk        in  1  rising-edge clock
//   rst_n      in  1  synchronous active-low reset
//   start      in  1  sweep request, honoured only in IDLE
//   expected   in  8  reference table, latched on accepted start
//   d          in  1  gate output under test
//   a, b, c    out 1  gate inputs; {a,b,c} is the current vector index
//   busy       out 1  sweep in progress (cycle after start through FINISH)
//   done       out 1  one-cycle pulse during FINISH
//   pass       out 1  table_out matched the reference (valid from FINISH)
//   table_out  out 8  captured table, bit i = d observed at vector i
// -----------------------------------------------------------------------------
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_VEC-1:0] expected,
    input  logic             d,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_VEC-1:0] table_out
);

    sweep_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [N_VEC-1:0] table_q, table_d;
    logic [N_VEC-1:0] exp_q,   exp_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             pass_q,  pass_d;

    logic             timer_clr_s;
    logic             timer_en_s;
    logic             timer_expire_s;
    logic [N_VEC-1:0] table_final_s;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr_s),
        .en     (timer_en_s),
        .expire (timer_expire_s)
    );

    // Table including the bit being sampled this cycle; lets pass be
    // registered together with the last capture so it is valid in FINISH.
    assign table_final_s = table_insert(table_q, idx_q, d);

    // Next-state and datapath control for the sweep.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        table_d     = table_q;
        exp_d       = exp_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        timer_clr_s = 1'b0;
        timer_en_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    idx_d       = {IDX_W{1'b0}};
                    table_d     = {N_VEC{1'b0}};
                    pass_d      = 1'b0;
                    exp_d       = expected;
                    busy_d      = 1'b1;
                    timer_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_SETTLE: begin
                timer_en_s = 1'b1;
                if (timer_expire_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end

            ST_SAMPLE: begin
                table_d     = table_final_s;
                timer_clr_s = 1'b1;
                if (idx_q == IDX_W'(N_VEC - 1)) begin
                    // Index stays at 111 so a/b/c hold the last vector.
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    pass_d  = (table_final_s == exp_q);
                end else begin
                    state_d = ST_SETTLE;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                // Unreachable encoding: recover to a quiet IDLE.
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                timer_clr_s = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; a reset mid-sweep
    // discards the partial table.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            table_q <= {N_VEC{1'b0}};
            exp_q   <= {N_VEC{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            table_q <= table_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // The index register is the stimulus vector: a is its MSB, c its LSB.
    assign a         = idx_q[2];
    assign b         = idx_q[1];
    assign c         = idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign table_out = table_q;

endmodule : truth_table_sweeper

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
// Two sweeper instances (SETTLE=1 and SETTLE=3) driving behavioural gate
// models. Each accepted start pushes the predicted table, pass flag and done
// cycle to a per-instance queue; a monitor pops and compares on every done.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    typedef struct {
        logic [7:0] tab;
        logic       pas;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    // Instance 1 (SETTLE=1)
    logic       start1, d1, a1, b1, c1, busy1, done1, pass1, dreg1;
    logic [7:0] exp1, tab1;
    int         mode1;
    bit         dly1;
    exp_t       q1[$];

    // Instance 3 (SETTLE=3)
    logic       start3, d3, a3, b3, c3, busy3, done3, pass3;
    logic [7:0] exp3, tab3;
    int         mode3;
    exp_t       q3[$];

    always #5 clk = ~clk;

    // Edge counter: after posedge N and #1, cyc == N.
    always @(posedge clk) cyc <= cyc + 1;

    // Gate models: 0 = AND, 1 = XOR, 2 = OR.
    function automatic logic gate_fn(input int mode, input logic [2:0] v);
        case (mode)
            0:       return &v;
            1:       return ^v;
            2:       return |v;
            default: return &v;
        endcase
    endfunction

    function automatic logic [7:0] model_table(input int mode);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = gate_fn(mode, 3'(i));
        return t;
    endfunction

    // Registered variant of the gate model for instance 1.
    always @(posedge clk) dreg1 <= gate_fn(mode1, {a1, b1, c1});

    assign d1 = dly1 ? dreg1 : gate_fn(mode1, {a1, b1, c1});
    assign d3 = gate_fn(mode3, {a3, b3, c3});

    truth_table_sweeper #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .d(d1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(tab1)
    );

    truth_table_sweeper #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .d(d3),
        .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3), .pass(pass3),
        .table_out(tab3)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Pulse start on one instance and record the prediction.
    task automatic start_sweep(input int which, input int mode, input logic [7:0] e, input bit dly);
        exp_t ex;
        @(posedge clk);
        #1;
        ex.tab = model_table(mode);
        ex.pas = (ex.tab == e);
        if (which == 1) begin
            mode1 = mode; dly1 = dly; exp1 = e; start1 = 1'b1;
            ex.cyc = cyc + 1 + 8 * 2;
            q1.push_back(ex);
        end else begin
            mode3 = mode; exp3 = e; start3 = 1'b1;
            ex.cyc = cyc + 1 + 8 * 4;
            q3.push_back(ex);
        end
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        for (int i = 0; i < budget && ((which == 1) ? q1.size() : q3.size()) != 0; i++)
            @(negedge clk);
        check_eq((which == 1) ? "timeout1" : "timeout3",
                 32'((which == 1) ? q1.size() : q3.size()), 32'd0);
    endtask

    // Scoreboard monitor, instance 1.
    always @(negedge clk) begin : mon1
        exp_t ex;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check_eq("unexpected_done1", 32'(done1), 32'd0);
            end else begin
                ex = q1.pop_front();
                check_eq("table1", 32'(tab1), 32'(ex.tab));
                check_eq("pass1", 32'(pass1), 32'(ex.pas));
                check_eq("done_time1", 32'(cyc), 32'(ex.cyc));
            end
        end
    end

    // Scoreboard monitor, instance 3.
    always @(negedge clk) begin : mon3
        exp_t ex;
        if (done3 === 1'b1) begin
            if (q3.size() == 0) begin
                check_eq("unexpected_done3", 32'(done3), 32'd0);
            end else begin
                ex = q3.pop_front();
                check_eq("table3", 32'(tab3), 32'(ex.tab));
                check_eq("pass3", 32'(pass3), 32'(ex.pas));
                check_eq("done_time3", 32'(cyc), 32'(ex.cyc));
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        start1 = 1'b0; exp1 = 8'h00; mode1 = 0; dly1 = 1'b0;
        start3 = 1'b0; exp3 = 8'h00; mode3 = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_abc1",   32'({a1, b1, c1}), 32'd0);
        check_eq("rst_busy1",  32'(busy1), 32'd0);
        check_eq("rst_done1",  32'(done1), 32'd0);
        check_eq("rst_pass1",  32'(pass1), 32'd0);
        check_eq("rst_table1", 32'(tab1), 32'd0);
        check_eq("rst_abc3",   32'({a3, b3, c3}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // AND gate, SETTLE=1: vectors step every 2 cycles.
        start_sweep(1, 0, 8'h80, 1'b0);
        @(negedge clk);
        check_eq("busy_after_start", 32'(busy1), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                repeat (2) @(posedge clk);
                @(negedge clk);
            end
            check_eq("vec_step1", 32'({a1, b1, c1}), 32'(k));
        end
        wait_done(1, 100);
        @(negedge clk);
        check_eq("abc_hold_111", 32'({a1, b1, c1}), 32'd7);
        check_eq("busy_after_finish", 32'(busy1), 32'd0);

        // OR gate against 0xFF: mismatch reported, results held afterwards.
        start_sweep(1, 2, 8'hFF, 1'b0);
        wait_done(1, 100);
        repeat (3) @(negedge clk);
        check_eq("table_hold", 32'(tab1), 32'(model_table(2)));
        check_eq("pass_hold", 32'(pass1), 32'd0);

        // Mid-sweep start pulse and reference change: ignored.
        start_sweep(1, 0, 8'h80, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        start1 = 1'b1;
        exp1 = 8'h00;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        wait_done(1, 100);

        // start held high: back-to-back sweeps with one IDLE cycle between.
        @(posedge clk);
        #1;
        mode1 = 1; exp1 = 8'h96; start1 = 1'b1;
        t0 = cyc + 1;
        q1.push_back('{tab: model_table(1), pas: 1'b1, cyc: t0 + 16});
        q1.push_back('{tab: model_table(1), pas: 1'b1, cyc: t0 + 34});
        repeat (18) @(posedge clk);
        @(negedge clk);
        check_eq("idle_gap_busy", 32'(busy1), 32'd0);
        @(posedge clk);
        #1;
        start1 = 1'b0;
        @(negedge clk);
        check_eq("restart_busy", 32'(busy1), 32'd1);
        wait_done(1, 100);

        // Reset while index == 4: everything clears, no done.
        start_sweep(1, 2, 8'hFE, 1'b0);
        for (int i = 0; i < 100 && {a1, b1, c1} != 3'd4; i++) @(negedge clk);
        check_eq("reach_idx4", 32'({a1, b1, c1}), 32'd4);
        rst_n = 1'b0;
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_abc", 32'({a1, b1, c1}), 32'd0);
        check_eq("mid_rst_busy", 32'(busy1), 32'd0);
        check_eq("mid_rst_table", 32'(tab1), 32'd0);
        check_eq("mid_rst_done", 32'(done1), 32'd0);
        repeat (40) @(negedge clk);
        start_sweep(1, 1, 8'h96, 1'b0);
        wait_done(1, 100);

        // Registered gate model: capture must still be correct.
        start_sweep(1, 1, 8'h96, 1'b1);
        wait_done(1, 100);
        start_sweep(1, 0, 8'h80, 1'b1);
        wait_done(1, 100);

        // SETTLE=3, XOR: vectors held 4 cycles, done 32 edges after start.
        start_sweep(3, 1, 8'h96, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                repeat (4) @(posedge clk);
                @(negedge clk);
            end
            check_eq("vec_step3", 32'({a3, b3, c3}), 32'(k));
        end
        wait_done(3, 200);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_truth_table_sweeper
